echo_meter: RTL and testbench

- Receive side of the ultrasonic ranging pair; the spike trigger generator fires the 10 us trig pulse and this block times the returning echo pulse.
- A start pulse arms it. It waits for the echo rising edge, measures the high time in clock ticks and converts that time to centimetres without a divider.
- Runs on the 6 MHz internal oscillator clock, sits beside the spike generator in top, and feeds distance results to display/UART logic.

---
 rtl/echo_pkg.sv | 17 +
 rtl/echo_sync.sv | 34 +++
 rtl/echo_meter.sv | 111 +++++++++++
 tb/tb_echo_meter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/echo_pkg.sv
// Shared definitions for the ultrasonic echo receiver.
package echo_pkg;

   // Default timing at the 6 MHz internal oscillator.
   localparam int unsigned ClkHz          = 6000000;
   localparam int unsigned DefTicksPerCm  = 348;     // 58 us per cm of range
   localparam int unsigned DefWaitTimeout = 228000;  // 38 ms without an echo edge
   localparam int unsigned DefMaxCm       = 400;

   typedef enum logic [1:0] {
      StIdle,
      StWaitRise,
      StMeasure,
      StDone
   } state_t;

endpackage

// File: rtl/echo_sync.sv
// Two-flop synchronizer for the raw echo pin plus registered edge pulses.
// A pin edge shows up on rise/fall three clocks later; both edges share the
// same latency so measured widths are unaffected.
module echo_sync (
   input  logic clk,
   input  logic rst,
   input  logic echo,
   output logic rise,
   output logic fall
);

   logic sync1_q, sync2_q, prev_q, rise_q, fall_q;

   // Synchronize the pin and register one-cycle edge pulses.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         prev_q  <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= echo;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         rise_q  <= sync2_q & ~prev_q;
         fall_q  <= ~sync2_q & prev_q;
      end
   end

   assign rise = rise_q;
   assign fall = fall_q;

endmodule

// File: rtl/echo_meter.sv
// Times the returning ultrasonic echo pulse and converts it to centimetres by
// counting whole TICKS_PER_CM periods, so no divider is needed.
module echo_meter
   import echo_pkg::*;
#(
   parameter int unsigned TICKS_PER_CM = DefTicksPerCm,
   parameter int unsigned WAIT_TIMEOUT = DefWaitTimeout,
   parameter int unsigned MAX_CM       = DefMaxCm,
   parameter int unsigned DIST_W       = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              echo,
   output logic [DIST_W-1:0] distance_cm,
   output logic              valid,
   output logic              overrange,
   output logic              timeout,
   output logic              busy
);

   localparam int unsigned WaitW  = (WAIT_TIMEOUT > 1) ? $clog2(WAIT_TIMEOUT) : 1;
   localparam int unsigned PrescW = (TICKS_PER_CM > 1) ? $clog2(TICKS_PER_CM) : 1;

   state_t              state_q;
   logic [WaitW-1:0]    wait_cnt_q;
   logic [PrescW-1:0]   presc_q;
   logic [DIST_W-1:0]   cm_cnt_q;
   logic [DIST_W-1:0]   dist_q;
   logic                valid_q, over_q, timeout_q;
   logic                rise, fall;
   logic                presc_wrap, sat_hit;
   logic [DIST_W-1:0]   cm_next;

   echo_sync u_sync (
      .clk  (clk),
      .rst  (rst),
      .echo (echo),
      .rise (rise),
      .fall (fall)
   );

   // Count value including the current high cycle.
   assign presc_wrap = (presc_q == PrescW'(TICKS_PER_CM - 1));
   assign cm_next    = presc_wrap ? cm_cnt_q + DIST_W'(1) : cm_cnt_q;
   assign sat_hit    = (cm_next == DIST_W'(MAX_CM));

   // Measurement FSM, counters and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         presc_q    <= '0;
         cm_cnt_q   <= '0;
         dist_q     <= '0;
         valid_q    <= 1'b0;
         over_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         valid_q   <= 1'b0;
         timeout_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (start) begin
                  state_q    <= StWaitRise;
                  wait_cnt_q <= '0;
                  presc_q    <= '0;
                  cm_cnt_q   <= '0;
               end
            end
            StWaitRise: begin
               // Only a low-to-high edge arms the measurement; a stale high level is ignored.
               if (rise) begin
                  state_q <= StMeasure;
               end else if (wait_cnt_q == WaitW'(WAIT_TIMEOUT - 1)) begin
                  state_q   <= StIdle;
                  timeout_q <= 1'b1;
                  over_q    <= 1'b0;
               end else begin
                  wait_cnt_q <= wait_cnt_q + WaitW'(1);
               end
            end
            StMeasure: begin
               // The falling-edge cycle is still counted so the width equals the high time;
               // the partial prescaler count is then dropped (floor).
               presc_q  <= presc_wrap ? '0 : presc_q + PrescW'(1);
               cm_cnt_q <= cm_next;
               if (fall || sat_hit) begin
                  state_q <= StDone;
                  dist_q  <= cm_next;
                  over_q  <= ~fall & sat_hit;
                  valid_q <= 1'b1;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign distance_cm = dist_q;
   assign valid       = valid_q;
   assign overrange   = over_q;
   assign timeout     = timeout_q;
   assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_echo_meter.sv
// Directed bench for echo_meter with small timing parameters.
module tb_echo_meter;

   localparam int unsigned TPC  = 4;
   localparam int unsigned WTO  = 100;
   localparam int unsigned MCM  = 20;
   localparam int unsigned DW   = 9;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          echo = 1'b0;
   logic [DW-1:0] distance_cm;
   logic          valid, overrange, timeout, busy;

   int vecs = 0;
   int errs = 0;
   int valid_cnt = 0;
   int timeout_cnt = 0;
   int both_cnt = 0;

   echo_meter #(
      .TICKS_PER_CM (TPC),
      .WAIT_TIMEOUT (WTO),
      .MAX_CM       (MCM),
      .DIST_W       (DW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .echo        (echo),
      .distance_cm (distance_cm),
      .valid       (valid),
      .overrange   (overrange),
      .timeout     (timeout),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Pulse counters sampled mid-cycle.
   always @(negedge clk) begin
      if (valid === 1'b1) valid_cnt++;
      if (timeout === 1'b1) timeout_cnt++;
      if (valid === 1'b1 && timeout === 1'b1) both_cnt++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_valid(input int bound, output int n, output bit seen);
      n = 0;
      seen = 1'b0;
      while (!seen && n < bound) begin
         step(1);
         n++;
         if (valid === 1'b1) seen = 1'b1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   // start, echo low for low_cyc, high for high_cyc; expects one result.
   task automatic run_echo(input string tag, input int low_cyc, input int high_cyc,
                           input int exp_cm);
      int v0, n;
      bit seen;
      v0 = valid_cnt;
      pulse_start();
      step(low_cyc);
      echo = 1'b1;
      step(high_cyc);
      echo = 1'b0;
      wait_valid(20, n, seen);
      chk({tag, "_seen"}, seen, 1);
      chk({tag, "_lat"}, n, 4);
      chk({tag, "_dist"}, distance_cm, exp_cm);
      chk({tag, "_ovr"}, overrange, 0);
      chk({tag, "_busy_done"}, busy, 1);
      step(1);
      chk({tag, "_busy_after"}, busy, 0);
      step(2);
      chk({tag, "_nvalid"}, valid_cnt - v0, 1);
   endtask

   // Echo held high 200 cycles; result must saturate.
   task automatic run_sat(input string tag);
      int v0, t0, n;
      bit seen;
      v0 = valid_cnt;
      t0 = timeout_cnt;
      pulse_start();
      step(3);
      echo = 1'b1;
      wait_valid(120, n, seen);
      chk({tag, "_seen"}, seen, 1);
      chk({tag, "_lat"}, n, 84);
      chk({tag, "_dist"}, distance_cm, MCM);
      chk({tag, "_ovr"}, overrange, 1);
      step(200 - n);
      chk({tag, "_nvalid"}, valid_cnt - v0, 1);
      chk({tag, "_ntimeout"}, timeout_cnt - t0, 0);
      chk({tag, "_idle"}, busy, 0);
      chk({tag, "_ovr_hold"}, overrange, 1);
      echo = 1'b0;
      step(6);
   endtask

   initial begin
      int v0, t0, n;
      bit seen;

      // Reset state
      rst = 1'b1;
      step(2);
      rst = 1'b0;
      chk("rst_busy", busy, 0);
      chk("rst_dist", distance_cm, 0);
      chk("rst_valid", valid, 0);
      chk("rst_ovr", overrange, 0);
      chk("rst_timeout", timeout, 0);
      step(3);

      // Nominal and truncation
      run_echo("nom", 10, 40, 10);
      run_echo("trunc43", 5, 43, 10);
      run_echo("trunc44", 5, 44, 11);

      // Saturation, then a nominal run clears overrange
      run_sat("sat1");
      run_echo("nom2", 10, 40, 10);

      // Saturation, then a timeout clears overrange and keeps distance
      run_sat("sat2");
      v0 = valid_cnt;
      t0 = timeout_cnt;
      echo = 1'b0;
      pulse_start();
      n = 0;
      seen = 1'b0;
      while (!seen && n < 150) begin
         step(1);
         n++;
         if (timeout === 1'b1) seen = 1'b1;
      end
      chk("to_seen", seen, 1);
      chk("to_lat", n, WTO);
      chk("to_valid", valid, 0);
      chk("to_dist", distance_cm, MCM);
      chk("to_ovr", overrange, 0);
      chk("to_busy", busy, 0);
      step(2);
      chk("to_ntimeout", timeout_cnt - t0, 1);
      chk("to_nvalid", valid_cnt - v0, 0);

      // Stale-high start, second start mid-measure ignored
      v0 = valid_cnt;
      echo = 1'b1;
      step(5);
      pulse_start();
      step(6);
      echo = 1'b0;
      step(10);
      echo = 1'b1;
      step(4);
      chk("stale_busy", busy, 1);
      pulse_start();
      step(3);
      echo = 1'b0;
      wait_valid(20, n, seen);
      chk("stale_seen", seen, 1);
      chk("stale_dist", distance_cm, 2);
      step(10);
      chk("stale_nvalid", valid_cnt - v0, 1);
      chk("stale_idle", busy, 0);

      // Reset during MEASURE aborts silently
      v0 = valid_cnt;
      t0 = timeout_cnt;
      pulse_start();
      step(3);
      echo = 1'b1;
      step(20);
      chk("abort_pre_busy", busy, 1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_dist", distance_cm, 0);
      chk("abort_valid", valid, 0);
      chk("abort_timeout", timeout, 0);
      echo = 1'b0;
      step(10);
      chk("abort_nvalid", valid_cnt - v0, 0);
      chk("abort_ntimeout", timeout_cnt - t0, 0);

      // Reset and start together: stays idle
      rst = 1'b1;
      start = 1'b1;
      step(1);
      rst = 1'b0;
      start = 1'b0;
      chk("rststart_busy0", busy, 0);
      step(1);
      chk("rststart_busy1", busy, 0);

      chk("valid_timeout_overlap", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
